// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: one bitmap bit per cover point in a single-port RAM,
// with distinct-hit counting, word readback and a swept (never reset) clear.
module cover_toggle_collector #(
  parameter  int COVER_TOTAL = 38253,
  parameter  int IDX_W       = 16,
  parameter  int WORD_W      = 32,
  localparam int WORDS       = (COVER_TOTAL + WORD_W - 1) / WORD_W,
  localparam int ADDR_W      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ev_valid,
  input  logic [IDX_W-1:0]  ev_index,
  output logic              ev_ready,
  input  logic              clear_req,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic [IDX_W-1:0]  hit_count,
  output logic              new_hit,
  output logic              oob_err,
  output logic              busy
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] HIT_MAX = IDX_W'(COVER_TOTAL);

  typedef enum logic [1:0] {CLEAR, IDLE, RMW} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   clr_addr;
  logic [ADDR_W-1:0]   cap_addr;
  logic [BIT_W-1:0]    cap_bit;
  logic [ADDR_W-1:0]   ev_word;
  logic [BIT_W-1:0]    ev_bit;
  logic                ev_in_range;
  logic                rd_in_range;
  logic                ev_take;
  logic                rd_take;
  logic                clr_last;
  logic                rmw_first;
  logic                rd_oob;
  logic [WORD_W-1:0]   rd_hold;

  logic                ram_we;
  logic                ram_re;
  logic [ADDR_W-1:0]   ram_addr;
  logic [WORD_W-1:0]   ram_wdata;
  logic [WORD_W-1:0]   ram_q;
  logic [WORD_W-1:0]   mem [WORDS];

  assign ev_word     = ADDR_W'(ev_index / IDX_W'(WORD_W));
  assign ev_bit      = BIT_W'(ev_index % IDX_W'(WORD_W));
  assign ev_in_range = ({1'b0, ev_index} < (IDX_W + 1)'(COVER_TOTAL));
  assign rd_in_range = ({1'b0, rd_addr} < (ADDR_W + 1)'(WORDS));
  assign rd_take     = (state == IDLE) && !clear_req && rd_en;
  assign ev_take     = (state == IDLE) && !clear_req && !rd_en && ev_valid;
  assign clr_last    = (clr_addr == ADDR_W'(WORDS - 1));
  assign rmw_first   = (state == RMW) && !ram_q[cap_bit];

  always_ff @(posedge clock) begin : state_reg
    if (!reset) state <= CLEAR;
    else        state <= state_next;
  end

  always_comb begin : next_state
    state_next = state;
    case (state)
      CLEAR:   if (clr_last) state_next = IDLE;
      IDLE: begin
        if (clear_req)                   state_next = CLEAR;
        else if (ev_take && ev_in_range) state_next = RMW;
      end
      RMW:     state_next = IDLE;
      default: state_next = CLEAR;
    endcase
  end

  // Writes are gated by reset so an abandoned RMW or sweep never lands in the RAM.
  always_comb begin : outputs
    busy      = 1'b0;
    ev_ready  = 1'b0;
    rd_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      CLEAR: begin
        busy     = 1'b1;
        ram_we   = reset;
        ram_addr = clr_addr;
      end
      IDLE: begin
        rd_ready = !clear_req;
        ev_ready = !clear_req && !rd_en;
        if (rd_take) begin
          ram_re   = rd_in_range;
          ram_addr = rd_addr;
        end else if (ev_take) begin
          ram_re   = ev_in_range;
          ram_addr = ev_word;
        end
      end
      RMW: begin
        ram_addr  = cap_addr;
        ram_wdata = ram_q | (WORD_W'(1) << cap_bit);
        ram_we    = reset && !ram_q[cap_bit];
      end
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin : bitmap_ram
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_q <= mem[ram_addr];
  end

  // The read strobe shows the RAM output directly; rd_hold keeps it afterwards.
  assign rd_data = rd_valid ? (rd_oob ? '0 : ram_q) : rd_hold;

  always_ff @(posedge clock) begin : datapath
    if (!reset) begin
      clr_addr  <= '0;
      cap_addr  <= '0;
      cap_bit   <= '0;
      hit_count <= '0;
      oob_err   <= 1'b0;
      new_hit   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_oob    <= 1'b0;
      rd_hold   <= '0;
    end else begin
      new_hit  <= 1'b0;
      rd_valid <= 1'b0;
      if (rd_valid) rd_hold <= rd_data;
      case (state)
        CLEAR: clr_addr <= clr_last ? '0 : clr_addr + ADDR_W'(1);
        IDLE: begin
          if (clear_req) begin
            clr_addr  <= '0;
            hit_count <= '0;
            oob_err   <= 1'b0;
          end else if (rd_take) begin
            rd_valid <= 1'b1;
            rd_oob   <= !rd_in_range;
          end else if (ev_take) begin
            if (ev_in_range) begin
              cap_addr <= ev_word;
              cap_bit  <= ev_bit;
            end else begin
              oob_err <= 1'b1;
            end
          end
        end
        RMW: begin
          if (rmw_first) begin
            new_hit <= 1'b1;
            if (hit_count != HIT_MAX) hit_count <= hit_count + IDX_W'(1);
          end
        end
        default: clr_addr <= '0;
      endcase
    end
  end

endmodule

// File: doc/cover_toggle_collector.md
COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

Interface
REQ-001 SHALL have parameter COVER_TOTAL, default 38253, number of toggle cover points tracked.
REQ-002 SHALL have parameter IDX_W, default 16, width of a cover index.
REQ-003 SHALL have parameter WORD_W, default 32, bitmap word width; WORDS = ceil(COVER_TOTAL/WORD_W) (1196 at defaults); ADDR_W = clog2(WORDS).
REQ-004 SHALL have port: clock  input  1  rising-edge clock.
REQ-005 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port: ev_valid  input  1  cover event present.
REQ-007 SHALL have port: ev_index  input  IDX_W  absolute cover index of event.
REQ-008 SHALL have port: ev_ready  output  1  event accepted when ev_valid && ev_ready.
REQ-009 SHALL have port: clear_req  input  1  request bitmap/counter clear.
REQ-010 SHALL have port: rd_en  input  1  bitmap word read request.
REQ-011 SHALL have port: rd_addr  input  ADDR_W  bitmap word address.
REQ-012 SHALL have port: rd_ready  output  1  read accepted when rd_en && rd_ready.
REQ-013 SHALL have port: rd_valid  output  1  one-cycle strobe, rd_data valid.
REQ-014 SHALL have port: rd_data  output  WORD_W  bitmap word; bit b = cover point addr*WORD_W+b hit.
REQ-015 SHALL have port: hit_count  output  IDX_W  number of distinct cover points hit.
REQ-016 SHALL have port: new_hit  output  1  one-cycle pulse on first hit of a point.
REQ-017 SHALL have port: oob_err  output  1  sticky, event with ev_index >= COVER_TOTAL seen.
REQ-018 SHALL have port: busy  output  1  high while clearing.

Function
REQ-019 SHALL hold bitmap in a WORDS x WORD_W single-port RAM; storage is not reset, only swept.
REQ-020 SHALL implement states CLEAR, IDLE, RMW.
REQ-021 In IDLE, priority SHALL be clear_req > rd_en > ev_valid; rd_ready = IDLE && !clear_req; ev_ready = IDLE && !clear_req && !rd_en.
REQ-022 IDLE + clear_req SHALL go to CLEAR, zero hit_count and oob_err in the same cycle.
REQ-023 CLEAR SHALL write zero to word 0..WORDS-1, one word per cycle, busy=1, ev_ready=rd_ready=0; after writing WORDS-1 go to IDLE (CLEAR lasts exactly WORDS cycles).
REQ-024 Accepted event with ev_index < COVER_TOTAL SHALL capture index, read word ev_index/WORD_W, go to RMW.
REQ-025 RMW SHALL, if bit ev_index%WORD_W is 0, write word with bit set, increment hit_count, assert new_hit next cycle; if already set, no write, no count, no pulse; always return to IDLE (2 cycles per event).
REQ-026 Accepted event with ev_index >= COVER_TOTAL SHALL be dropped, set oob_err, stay IDLE, no RAM access.
REQ-027 Accepted read SHALL return rd_data with rd_valid exactly 1 cycle later; rd_addr >= WORDS returns 0; state stays IDLE.
REQ-028 rd_data SHALL hold last value between reads; new_hit and rd_valid SHALL be single-cycle pulses.
REQ-029 hit_count SHALL never exceed COVER_TOTAL; no wrap.
REQ-030 clear_req outside IDLE SHALL be ignored (not latched); events and reads are never dropped once accepted.

Reset
REQ-031 reset=0 at a rising edge SHALL force state CLEAR at word 0, hit_count=0, oob_err=0, new_hit=0, rd_valid=0, rd_data=0, ev_ready=0, rd_ready=0, busy=1.
REQ-032 Reset mid-RMW or mid-CLEAR SHALL abandon the operation and restart the full sweep; no pending write completes.

Verification
REQ-033 Release reset -> busy=1 for exactly 1196 cycles, then ev_ready=1, hit_count=0; read addr 0..1195 all return 0.
REQ-034 Events 5, 5, 38252 -> hit_count=2, new_hit pulses twice; read addr 0 -> 0x00000020, addr 1195 -> 0x00001000 (bit 12).
REQ-035 Event 38253 -> oob_err=1, hit_count unchanged; then clear_req -> oob_err=0, hit_count=0, busy for 1196 cycles.
REQ-036 ev_valid, rd_en, clear_req asserted together in IDLE -> clear taken, rd_ready=ev_ready=0; after sweep read then event serviced in that order.
REQ-037 Back-to-back ev_valid held high with indices 0..31 -> one acceptance every 2 cycles, hit_count=32, word 0 = 0xFFFFFFFF.
REQ-038 reset asserted in the RMW cycle of event 7 -> after new sweep, word 0 = 0, hit_count=0.
